// File: rtl/axi_mem_if_pkg.sv
// Shared types and memory-port polarity constants for the two-requester memory arbiter.
package axi_mem_if_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_RD   = 2'd1,
      OWN_WR   = 2'd2
   } owner_e;

   // Single-port SRAM strobes are active-low; WEN low selects a write.
   localparam logic CEN_ON    = 1'b0;
   localparam logic CEN_OFF   = 1'b1;
   localparam logic WEN_WRITE = 1'b0;
   localparam logic WEN_READ  = 1'b1;

   localparam int REQ_RD = 0;
   localparam int REQ_WR = 1;

   function automatic owner_e grant_owner(input logic [1:0] gnt);
      owner_e o;
      o = OWN_NONE;
      if (gnt[REQ_RD])      o = OWN_RD;
      else if (gnt[REQ_WR]) o = OWN_WR;
      return o;
   endfunction

endpackage

// File: rtl/axi_mem_arbiter_if.sv
// Requester and memory-port bundle between the arbiter and its surroundings.
interface axi_mem_arbiter_if #(
   parameter int MEM_ADDR_WIDTH = 13,
   parameter int DATA_WIDTH     = 64,
   parameter int NUMBYTES       = DATA_WIDTH / 8
);
   logic                      rd_valid_i;
   logic [MEM_ADDR_WIDTH-1:0] rd_addr_i;
   logic                      rd_grant_o;
   logic                      rd_rvalid_o;
   logic [DATA_WIDTH-1:0]     rd_rdata_o;

   logic                      wr_valid_i;
   logic [MEM_ADDR_WIDTH-1:0] wr_addr_i;
   logic [DATA_WIDTH-1:0]     wr_data_i;
   logic [NUMBYTES-1:0]       wr_be_i;
   logic                      wr_grant_o;

   logic                      mem_cen_o;
   logic                      mem_wen_o;
   logic [MEM_ADDR_WIDTH-1:0] mem_a_o;
   logic [DATA_WIDTH-1:0]     mem_d_o;
   logic [NUMBYTES-1:0]       mem_be_o;
   logic [DATA_WIDTH-1:0]     mem_q_i;

   modport slave (
      input  rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, mem_q_i,
      output rd_grant_o, rd_rvalid_o, rd_rdata_o, wr_grant_o,
             mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o
   );

   modport master (
      output rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i, wr_be_i, mem_q_i,
      input  rd_grant_o, rd_rvalid_o, rd_rdata_o, wr_grant_o,
             mem_cen_o, mem_wen_o, mem_a_o, mem_d_o, mem_be_o
   );

endinterface

// File: rtl/axi_mem_rr_hold.sv
// Two-requester arbiter with burst stickiness: the owner keeps the grant under
// contention until it has had MAX_HOLD consecutive grants, then the other side wins.
module axi_mem_rr_hold
   import axi_mem_if_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   localparam int               CNT_W    = $clog2(MAX_HOLD) + 1;
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

   owner_e           owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_wr_q, last_wr_d;
   logic             hold_done;

   assign hold_done = (cnt_q >= HOLD_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q   <= OWN_NONE;
         cnt_q     <= '0;
         last_wr_q <= 1'b1;
      end else begin
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         last_wr_q <= last_wr_d;
      end
   end

   always_comb begin
      owner_e gnt_own;
      gnt       = 2'b00;
      owner_d   = owner_q;
      cnt_d     = cnt_q;
      last_wr_d = last_wr_q;

      if (!rst) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
               case (owner_q)
                  OWN_RD:  gnt = hold_done ? 2'b10 : 2'b01;
                  OWN_WR:  gnt = hold_done ? 2'b01 : 2'b10;
                  default: gnt = last_wr_q ? 2'b01 : 2'b10;
               endcase
            end
            default: gnt = 2'b00;
         endcase
      end

      // Counter saturates so a long uncontended burst cannot wrap back under the limit.
      gnt_own = grant_owner(gnt);
      if (gnt_own == OWN_NONE) begin
         owner_d = OWN_NONE;
         cnt_d   = '0;
      end else begin
         last_wr_d = (gnt_own == OWN_WR);
         if (gnt_own == owner_q) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
         end else begin
            owner_d = gnt_own;
            cnt_d   = '0;
         end
      end
   end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one single-port memory between a read and a write requester: grant,
// address/data muxing, and one-cycle read-return strobe.
module axi_mem_arbiter
   import axi_mem_if_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 13,
   parameter int DATA_WIDTH     = 64,
   parameter int NUMBYTES       = DATA_WIDTH / 8,
   parameter int MAX_HOLD       = 8
) (
   input logic              clk,
   input logic              rst,
   axi_mem_arbiter_if.slave bus
);

   logic [1:0]                gnt;
   logic                      rd_pend_q;
   logic [MEM_ADDR_WIDTH-1:0] mem_a;
   logic [DATA_WIDTH-1:0]     mem_d;
   logic [NUMBYTES-1:0]       mem_be;

   axi_mem_rr_hold #(
      .MAX_HOLD (MAX_HOLD)
   ) u_hold (
      .clk (clk),
      .rst (rst),
      .req ({bus.wr_valid_i, bus.rd_valid_i}),
      .gnt (gnt)
   );

   // Idle cycles present the write port so the address/data bus only toggles with writes.
   always_comb begin
      mem_a  = bus.wr_addr_i;
      mem_d  = bus.wr_data_i;
      mem_be = bus.wr_be_i;
      if (gnt[REQ_RD]) begin
         mem_a  = bus.rd_addr_i;
         mem_be = '1;
      end
   end

   // Memory returns data the cycle after the access; each read grant gets its own strobe.
   always_ff @(posedge clk) begin
      if (rst) rd_pend_q <= 1'b0;
      else     rd_pend_q <= gnt[REQ_RD];
   end

   assign bus.rd_grant_o  = gnt[REQ_RD];
   assign bus.wr_grant_o  = gnt[REQ_WR];
   assign bus.mem_cen_o   = (|gnt) ? CEN_ON : CEN_OFF;
   assign bus.mem_wen_o   = gnt[REQ_WR] ? WEN_WRITE : WEN_READ;
   assign bus.mem_a_o     = mem_a;
   assign bus.mem_d_o     = mem_d;
   assign bus.mem_be_o    = mem_be;
   assign bus.rd_rvalid_o = rd_pend_q;
   assign bus.rd_rdata_o  = bus.mem_q_i;

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 13, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, memory data width.
REQ-003 SHALL have parameter NUMBYTES, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grants to one requester while the other waits.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous to clk, active-high.
REQ-007 SHALL have ports rd_valid_i  in  1, rd_addr_i  in  MEM_ADDR_WIDTH  read requester access request and word address.
REQ-008 SHALL have ports rd_grant_o  out  1, rd_rvalid_o  out  1, rd_rdata_o  out  DATA_WIDTH  read grant, read-data strobe and read data.
REQ-009 SHALL have ports wr_valid_i  in  1, wr_addr_i  in  MEM_ADDR_WIDTH, wr_data_i  in  DATA_WIDTH, wr_be_i  in  NUMBYTES  write requester request, address, data and byte enables.
REQ-010 SHALL have port wr_grant_o  out  1  write grant.
REQ-011 SHALL have ports mem_cen_o  out  1 (active-low), mem_wen_o  out  1 (0=write), mem_a_o  out  MEM_ADDR_WIDTH, mem_d_o  out  DATA_WIDTH, mem_be_o  out  NUMBYTES, mem_q_i  in  DATA_WIDTH  single-port memory.

Function
REQ-012 SHALL compute grants combinationally from the valid inputs in the same cycle; at most one grant high per cycle; a grant never asserts without its valid.
REQ-013 SHALL keep an owner FSM with states NONE, RD, WR, plus a last_served flag and a hold counter (width $clog2(MAX_HOLD)+1, saturating).
REQ-014 Only one valid -> grant it. Neither valid -> no grant, mem_cen_o=1.
REQ-015 Both valid, owner RD or WR, hold counter < MAX_HOLD-1 -> grant the owner (burst stickiness).
REQ-016 Both valid, owner at hold counter >= MAX_HOLD-1 -> grant the other requester.
REQ-017 Both valid, owner NONE -> grant the requester opposite last_served.
REQ-018 On each clock edge, a grant to the current owner increments the hold counter; a grant to the other requester sets owner to it and clears the counter; no grant sets owner NONE and clears the counter; last_served takes the granted requester and holds when none is granted.
REQ-019 Read grant -> mem_cen_o=0, mem_wen_o=1, mem_a_o=rd_addr_i, mem_be_o all-ones.
REQ-020 Write grant -> mem_cen_o=0, mem_wen_o=0, mem_a_o=wr_addr_i, mem_d_o=wr_data_i, mem_be_o=wr_be_i.
REQ-021 No grant -> mem_cen_o=1, mem_wen_o=1; address/data/be are don't-care but SHALL follow write-port inputs.
REQ-022 rd_rvalid_o SHALL be high exactly one cycle after each read grant (registered); rd_rdata_o = mem_q_i combinationally.
REQ-023 Back-to-back read grants SHALL produce rd_rvalid_o high on consecutive cycles with no gap.
REQ-024 A write grant following a read grant SHALL not suppress the pending rd_rvalid_o of the earlier read.

Reset
REQ-025 While rst=1, grants SHALL be 0 and mem_cen_o=1 regardless of valids.
REQ-026 On reset: owner NONE, hold counter 0, last_served WR (read wins the first contention), rd_rvalid_o 0.
REQ-027 Reset asserted mid-burst SHALL drop the outstanding rd_rvalid_o on the next edge and restart arbitration afresh after release.

Structure
REQ-028 The owner-state enum and response-free memory-port constants (CEN/WEN polarity) SHALL live in shared package axi_mem_if_pkg.
REQ-029 Priority/hold logic SHALL be a sub-module axi_mem_rr_hold, 2-requester, parameterised by MAX_HOLD; top adds muxing and read-return tracking.

Verification (MAX_HOLD=4)
REQ-030 Reset release, rd_valid_i=wr_valid_i=1 continuously -> grants RD,RD,RD,RD,WR,WR,WR,WR,RD... (4-cycle alternation).
REQ-031 Only wr_valid_i=1, addr 0x010, be 0x0F, 3 cycles -> wr_grant_o 3 cycles, mem_wen_o=0, mem_a_o=0x010, mem_be_o=0x0F, no switch.
REQ-032 Single read addr 0x1FF, mem_q_i=0xDEAD_BEEF next cycle -> rd_rvalid_o pulse 1 cycle later, rd_rdata_o=0xDEAD_BEEF.
REQ-033 Owner RD with counter 1, wr_valid_i rises -> read keeps grant 2 more cycles, then write granted; idle cycle between -> next contention goes to requester not last served.
REQ-034 rst pulsed during read burst with rd_grant_o high -> grants 0 and mem_cen_o=1 same cycle, rd_rvalid_o 0 next cycle, first contention after release goes to read.
